// File: rtl/rv32_multicycle_core_if.sv
// Instruction-memory bus between the core (master) and a synchronous ROM/BRAM (slave).
// Read data is expected one cycle after the address is presented.
interface rv32_multicycle_core_if #(
  parameter int AW = 8
) ();
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/rv32_multicycle_core.sv
// Two-cycle-per-instruction RV32I-subset core: FETCH presents PC to the memory,
// EXEC decodes the returned word, writes rd and advances PC.
//   state   | meaning
//   S_FETCH | imem_addr driven from pc, no architectural change
//   S_EXEC  | decode imem_rdata, write rd, update pc, count retire
//   S_HALT  | stopped on EBREAK or trap, held until rst
module rv32_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 8,
  parameter int          CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  rv32_multicycle_core_if.master imem,
  input  logic [4:0]             dbg_sel,
  output logic [31:0]            dbg_data,
  output logic [31:0]            pc,
  output logic                   halted,
  output logic                   illegal,
  output logic [CNT_W-1:0]       retired
);

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] EBREAK     = 32'h0010_0073;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] rf [32];
  logic [31:0] instr, rs1_val, rs2_val;
  logic [31:0] imm_i, imm_b, imm_u, imm_j;
  logic [31:0] pc_plus4, tgt_b, tgt_j, pc_next, rd_wdata;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        rd_we, trap, brk, taken;

  function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'b0, $signed(a) < $signed(b)};
      3'd3:    return {31'b0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign instr  = imem.imem_rdata;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // rf[0] is cleared on reset and never written, so x0 reads as zero
  assign rs1_val  = rf[rs1];
  assign rs2_val  = rf[rs2];
  assign dbg_data = (dbg_sel == 5'd0) ? 32'b0 : rf[dbg_sel];

  assign pc_plus4       = pc + 32'd4;
  assign tgt_b          = pc + imm_b;
  assign tgt_j          = pc + imm_j;
  assign imem.imem_addr = pc[IMEM_AW+1:2];
  assign halted         = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_we     = 1'b0;
    rd_wdata  = 32'b0;
    pc_next   = pc_plus4;
    trap      = 1'b0;
    brk       = 1'b0;
    taken     = 1'b0;
    case (state)
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        case (opcode)
          OPC_OP: begin
            if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
              rd_we    = 1'b1;
              rd_wdata = alu(f3, instr[30], rs1_val, rs2_val);
            end else trap = 1'b1;
          end
          OPC_OPIMM: begin
            // only shifts constrain imm[11:5]; SRAI is the one that allows 0x20
            if ((f3 == 3'd1 && f7 != 7'h00) ||
                (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) trap = 1'b1;
            else begin
              rd_we    = 1'b1;
              rd_wdata = alu(f3, (f3 == 3'd5) && instr[30], rs1_val, imm_i);
            end
          end
          OPC_LUI: begin
            rd_we    = 1'b1;
            rd_wdata = imm_u;
          end
          OPC_JAL: begin
            if (tgt_j[1:0] != 2'b00) trap = 1'b1;
            else begin
              rd_we    = 1'b1;
              rd_wdata = pc_plus4;
              pc_next  = tgt_j;
            end
          end
          OPC_BRANCH: begin
            case (f3)
              3'd0:    taken = (rs1_val == rs2_val);
              3'd1:    taken = (rs1_val != rs2_val);
              3'd4:    taken = ($signed(rs1_val) <  $signed(rs2_val));
              3'd5:    taken = ($signed(rs1_val) >= $signed(rs2_val));
              3'd6:    taken = (rs1_val <  rs2_val);
              3'd7:    taken = (rs1_val >= rs2_val);
              default: trap  = 1'b1;
            endcase
            if (taken) begin
              if (tgt_b[1:0] != 2'b00) trap = 1'b1;
              else                     pc_next = tgt_b;
            end
          end
          default: begin
            if (instr == EBREAK) brk = 1'b1;
            else                 trap = 1'b1;
          end
        endcase
        if (trap || brk) state_nxt = S_HALT;
      end
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      retired <= '0;
      illegal <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'b0;
    end else if (state == S_EXEC) begin
      if (trap) illegal <= 1'b1;
      else begin
        retired <= retired + CNT_W'(1);
        if (!brk) pc <= pc_next;
        if (rd_we && rd != 5'd0) rf[rd] <= rd_wdata;
      end
    end
  end

endmodule

// File: tb/tb_rv32_multicycle_core.sv
// Runs short programs from a synchronous ROM model; expected architectural
// state is queued per program and compared once the core halts or is reset.
module tb_rv32_multicycle_core;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [4:0]        dbg_sel = 5'd0;
  logic [31:0]       dbg_data, pc;
  logic              halted, illegal;
  logic [31:0]       retired;
  logic [31:0]       mem [256];
  int                n_tests = 0;
  int                n_fail = 0;
  int                cyc;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum {K_REG, K_PC, K_RET, K_ILL, K_HALT} kind_t;
  typedef struct {
    kind_t       kind;
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;
  exp_t sb [$];

  rv32_multicycle_core_if #(.AW(8)) imem ();

  rv32_multicycle_core #(.RESET_PC(32'h0), .IMEM_AW(8), .CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .imem     (imem.master),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .pc       (pc),
    .halted   (halted),
    .illegal  (illegal),
    .retired  (retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem.imem_rdata <= mem[imem.imem_addr];

  function automatic logic [31:0] op_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] op_i(int imm, int rs1, int f3, int rd);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'h13};
  endfunction
  function automatic logic [31:0] lui(int rd, int imm20);
    return {20'(imm20), 5'(rd), 7'h37};
  endfunction
  function automatic logic [31:0] jal(int rd, int off);
    logic [20:0] o;
    o = 21'(off);
    return {o[20], o[10:1], o[11], o[19:12], 5'(rd), 7'h6F};
  endfunction
  function automatic logic [31:0] br(int f3, int rs1, int rs2, int off);
    logic [12:0] o;
    o = 13'(off);
    return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'(f3), o[4:1], o[11], 7'h63};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input kind_t k, input int sel, input logic [31:0] v, input string tag);
    exp_t e;
    e.kind = k; e.sel = sel; e.val = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_REG: begin
          dbg_sel = 5'(e.sel);
          #1;
          check(e.tag, dbg_data, e.val);
        end
        K_PC:    check(e.tag, pc, e.val);
        K_RET:   check(e.tag, retired, e.val);
        K_ILL:   check(e.tag, {31'b0, illegal}, e.val);
        default: check(e.tag, {31'b0, halted}, e.val);
      endcase
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic run_until_halt(input int max, output int n);
    n = 0;
    while (n < max) begin
      @(posedge clk);
      #1;
      n++;
      if (halted) break;
    end
    if (!halted) check("halt_timeout", {31'b0, halted}, 32'd1);
  endtask

  task automatic load_count_prog();
    clear_mem();
    mem[0] = op_r(0, 0, 0, 0, 1);
    for (int i = 1; i <= 9; i++) mem[i] = op_i(1, 1, 0, 1);
    mem[10] = op_r(0, 0, 1, 0, 2);
    mem[11] = op_r(0, 2, 1, 0, 3);
    mem[12] = EBREAK;
  endtask

  initial begin
    // reset state
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    push(K_PC,   0, 32'h0, "rst_pc");
    push(K_RET,  0, 32'h0, "rst_retired");
    push(K_HALT, 0, 32'h0, "rst_halted");
    push(K_ILL,  0, 32'h0, "rst_illegal");
    drain();

    // counting program, exact halt latency
    load_count_prog();
    do_reset();
    run_until_halt(100, cyc);
    check("t1_cycles", 32'(cyc), 32'd26);
    push(K_REG, 1, 32'd9, "t1_x1");
    push(K_REG, 2, 32'd9, "t1_x2");
    push(K_REG, 3, 32'd18, "t1_x3");
    push(K_HALT, 0, 32'd1, "t1_halted");
    push(K_RET, 0, 32'd13, "t1_retired");
    push(K_ILL, 0, 32'd0, "t1_illegal");
    push(K_PC, 0, 32'h30, "t1_pc");
    drain();

    // shifts and compares on all-ones
    clear_mem();
    mem[0] = op_i(-1, 0, 0, 5);
    mem[1] = op_i(32'h404, 5, 5, 6);
    mem[2] = op_i(28, 5, 5, 7);
    mem[3] = op_r(0, 5, 0, 3, 8);
    mem[4] = op_r(0, 0, 5, 2, 9);
    mem[5] = EBREAK;
    do_reset();
    run_until_halt(100, cyc);
    push(K_REG, 5, 32'hFFFF_FFFF, "t2_x5");
    push(K_REG, 6, 32'hFFFF_FFFF, "t2_srai");
    push(K_REG, 7, 32'h0000_000F, "t2_srli");
    push(K_REG, 8, 32'd1, "t2_sltu");
    push(K_REG, 9, 32'd1, "t2_slt");
    push(K_RET, 0, 32'd6, "t2_retired");
    drain();

    // x0, LUI, logic ops, sign-extended immediate, rs-before-rd
    clear_mem();
    mem[0]  = op_i(5, 0, 0, 0);
    mem[1]  = lui(4, 32'hABCDE);
    mem[2]  = op_i(32'h123, 0, 0, 10);
    mem[3]  = op_i(4, 10, 1, 11);
    mem[4]  = op_r(32, 11, 10, 0, 12);
    mem[5]  = op_i(32'hFF, 10, 4, 13);
    mem[6]  = op_i(32'hF0, 10, 7, 14);
    mem[7]  = op_i(-2048, 10, 6, 15);
    mem[8]  = op_i(7, 0, 0, 16);
    mem[9]  = op_r(0, 16, 16, 0, 16);
    mem[10] = EBREAK;
    do_reset();
    run_until_halt(100, cyc);
    push(K_REG, 0, 32'h0, "t3_x0");
    push(K_REG, 4, 32'hABCD_E000, "t3_lui");
    push(K_REG, 11, 32'h0000_1230, "t3_slli");
    push(K_REG, 12, 32'hFFFF_EEF3, "t3_sub");
    push(K_REG, 13, 32'h0000_01DC, "t3_xori");
    push(K_REG, 14, 32'h0000_0020, "t3_andi");
    push(K_REG, 15, 32'hFFFF_F923, "t3_ori_sext");
    push(K_REG, 16, 32'd14, "t3_double");
    push(K_RET, 0, 32'd11, "t3_retired");
    drain();

    // countdown loop, BNE taken twice
    clear_mem();
    mem[0] = op_i(3, 0, 0, 1);
    mem[1] = op_i(-1, 1, 0, 1);
    mem[2] = br(1, 1, 0, -4);
    mem[3] = EBREAK;
    do_reset();
    run_until_halt(100, cyc);
    push(K_REG, 1, 32'd0, "t4_x1");
    push(K_RET, 0, 32'd8, "t4_retired");
    push(K_PC, 0, 32'hC, "t4_pc");
    push(K_ILL, 0, 32'd0, "t4_illegal");
    drain();

    // JAL then undecodable opcode
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = 32'h0000_0013;
    mem[4] = jal(1, 8);
    mem[6] = 32'h0000_007F;
    do_reset();
    run_until_halt(100, cyc);
    push(K_REG, 1, 32'h14, "t5_link");
    push(K_PC, 0, 32'h18, "t5_pc");
    push(K_HALT, 0, 32'd1, "t5_halted");
    push(K_ILL, 0, 32'd1, "t5_illegal");
    push(K_RET, 0, 32'd5, "t5_retired");
    drain();

    // taken branch to a misaligned target
    clear_mem();
    mem[0] = op_i(1, 0, 0, 1);
    mem[1] = br(0, 0, 0, 2);
    do_reset();
    run_until_halt(100, cyc);
    push(K_ILL, 0, 32'd1, "t6_mis_illegal");
    push(K_PC, 0, 32'h4, "t6_mis_pc");
    push(K_RET, 0, 32'd1, "t6_mis_retired");
    drain();

    // OP with unsupported funct7
    clear_mem();
    mem[0] = op_r(1, 2, 1, 0, 3);
    do_reset();
    run_until_halt(100, cyc);
    push(K_ILL, 0, 32'd1, "t6_f7_illegal");
    push(K_RET, 0, 32'd0, "t6_f7_retired");
    push(K_REG, 3, 32'd0, "t6_f7_nowrite");
    drain();

    // reset mid-EXEC of an endless loop
    clear_mem();
    mem[0] = op_i(1, 1, 0, 1);
    mem[1] = jal(0, -4);
    do_reset();
    repeat (7) @(posedge clk);
    #1;
    check("t7_pre_retired", retired, 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push(K_PC, 0, 32'h0, "t7_rst_pc");
    push(K_RET, 0, 32'd0, "t7_rst_retired");
    for (int r = 1; r < 32; r++) push(K_REG, r, 32'd0, $sformatf("t7_rst_x%0d", r));
    drain();

    // reset while halted, then a clean rerun
    load_count_prog();
    @(negedge clk) rst = 1'b0;
    run_until_halt(100, cyc);
    check("t8_first_halt", {31'b0, halted}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push(K_HALT, 0, 32'd0, "t8_rst_halted");
    push(K_PC, 0, 32'h0, "t8_rst_pc");
    drain();
    @(negedge clk) rst = 1'b0;
    run_until_halt(100, cyc);
    check("t8_rerun_cycles", 32'(cyc), 32'd26);
    push(K_REG, 3, 32'd18, "t8_rerun_x3");
    push(K_RET, 0, 32'd13, "t8_rerun_retired");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
